// File: rtl/rdy_ack_packer_pkg.sv
// Shared sizing helpers for the rdy/ack width-up packer family.
package rdy_ack_packer_pkg;

  function automatic int packed_width(input int n_m1, input int dw_m1);
    return (n_m1 + 1) * (dw_m1 + 1);
  endfunction

  // LSB position of slot k inside a packed word.
  function automatic int slot_lsb(input int k, input int dw_m1);
    return k * (dw_m1 + 1);
  endfunction

endpackage

// File: rtl/rdy_ack_out_reg.sv
// Single-entry rdy/ack output holding register with a load port.
module rdy_ack_out_reg #(
  parameter int W_M1 = 31
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_load,
  input  logic [W_M1:0] i_data,
  output logic        o_free,
  output logic        o_rdy,
  input  logic        o_ack,
  output logic [W_M1:0] o_data
);

  logic        r_rdy;
  logic [W_M1:0] r_data;

  // Free when empty or being drained this cycle, so reload is bubble-free.
  assign o_free = !r_rdy | o_ack;
  assign o_rdy  = r_rdy;
  assign o_data = r_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdy  <= 1'b0;
      r_data <= '0;
    end else if (i_load) begin
      r_rdy  <= 1'b1;
      r_data <= i_data;
    end else if (r_rdy && o_ack) begin
      r_rdy  <= 1'b0;
    end
  end

endmodule

// File: rtl/rdy_ack_packer.sv
// Packs N narrow rdy/ack words into one wide word; i_last closes a word early.
module rdy_ack_packer
  import rdy_ack_packer_pkg::*;
#(
  parameter int DW_M1 = 8,
  parameter int N_M1  = 3,
  parameter int CW_M1 = 1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             i_rdy,
  output logic                             i_ack,
  input  logic [DW_M1:0]                   i_data,
  input  logic                             i_last,
  output logic                             o_rdy,
  input  logic                             o_ack,
  output logic [(N_M1+1)*(DW_M1+1)-1:0]    o_data,
  output logic [CW_M1:0]                   o_cnt,
  output logic                             o_last,
  output logic                             busy
);

  localparam int DW = DW_M1 + 1;
  localparam int OW = packed_width(N_M1, DW_M1);
  localparam logic [CW_M1:0] LAST_IDX = N_M1[CW_M1:0];

  logic [CW_M1:0]    r_idx;
  logic              w_free;
  logic              w_accept;
  logic              w_done;
  logic [OW-1:0]     w_word;
  logic [OW+CW_M1+1:0] w_out;

  assign i_ack    = w_free;
  assign w_accept = i_rdy & w_free;
  assign w_done   = w_accept & ((r_idx == LAST_IDX) | i_last);
  assign busy     = (r_idx != '0);

  genvar gi;
  generate
    for (gi = 0; gi <= N_M1; gi++) begin : gen_slot
      localparam int SLOT_I = gi;
      localparam logic [CW_M1:0] SLOT = SLOT_I[CW_M1:0];
      logic [DW_M1:0] r_slot;

      // Current slot takes the live input; slots above it are forced to zero.
      assign w_word[slot_lsb(gi, DW_M1) +: DW] =
        (r_idx == SLOT) ? i_data : ((r_idx > SLOT) ? r_slot : '0);

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_slot <= '0;
        end else if (w_done) begin
          r_slot <= '0;
        end else if (w_accept && (r_idx == SLOT)) begin
          r_slot <= i_data;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx <= '0;
    end else if (w_done) begin
      r_idx <= '0;
    end else if (w_accept) begin
      r_idx <= r_idx + 1'b1;
    end
  end

  rdy_ack_out_reg #(
    .W_M1 (OW + CW_M1 + 1)
  ) u_out (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (w_done),
    .i_data ({i_last, r_idx, w_word}),
    .o_free (w_free),
    .o_rdy  (o_rdy),
    .o_ack  (o_ack),
    .o_data (w_out)
  );

  assign {o_last, o_cnt, o_data} = w_out;

endmodule

// File: tb/tb_rdy_ack_packer.sv
// Scoreboard bench for rdy_ack_packer (DW_M1=7, N_M1=3, CW_M1=1).
module tb_rdy_ack_packer;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  cnt;
    logic        last;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        i_rdy;
  logic        i_ack;
  logic [7:0]  i_data;
  logic        i_last;
  logic        o_rdy;
  logic        o_ack;
  logic [31:0] o_data;
  logic [1:0]  o_cnt;
  logic        o_last;
  logic        busy;

  exp_t sb_q[$];
  int   n_vec  = 0;
  int   n_miss = 0;
  bit   verbose  = 1;
  bit   rand_done = 0;

  rdy_ack_packer #(
    .DW_M1 (7),
    .N_M1  (3),
    .CW_M1 (1)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_rdy  (i_rdy),
    .i_ack  (i_ack),
    .i_data (i_data),
    .i_last (i_last),
    .o_rdy  (o_rdy),
    .o_ack  (o_ack),
    .o_data (o_data),
    .o_cnt  (o_cnt),
    .o_last (o_last),
    .busy   (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] d, input logic [1:0] c, input logic l);
    exp_t e;
    e.data = d;
    e.cnt  = c;
    e.last = l;
    sb_q.push_back(e);
  endtask

  // Monitor: every output handshake pops one expected word.
  always @(negedge clk) begin
    if (rst_n && o_rdy && o_ack) begin
      n_vec++;
      if (sb_q.size() == 0) begin
        n_miss++;
        $display("FAIL out_word: got data=0x%08h cnt=%0d last=%0d, expected no word", o_data, o_cnt, o_last);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        if ({o_data, o_cnt, o_last} !== e) begin
          n_miss++;
          $display("FAIL out_word: got data=0x%08h cnt=%0d last=%0d, expected data=0x%08h cnt=%0d last=%0d",
                   o_data, o_cnt, o_last, e.data, e.cnt, e.last);
        end else if (verbose) begin
          $display("word ok data=0x%08h cnt=%0d last=%0d", o_data, o_cnt, o_last);
        end
      end
    end
  end

  // Holds i_rdy until the word is accepted; waits = cycles stalled before accept.
  task automatic send(input logic [7:0] d, input logic l, output int waits);
    logic a;
    a = 1'b0;
    waits = 0;
    i_rdy  = 1'b1;
    i_data = d;
    i_last = l;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      a = i_ack;
      @(posedge clk);
      #1;
      if (a) break;
      waits++;
    end
    if (!a) check("send_accept", a, 1);
  endtask

  task automatic idle(input int n);
    i_rdy = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int w;
    logic [7:0] m_acc[4];
    int m_idx;

    rst_n = 1'b0; i_rdy = 1'b0; i_data = '0; i_last = 1'b0; o_ack = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ordy", o_rdy, 0);
    check("rst_odata", o_data, 0);
    check("rst_ocnt", o_cnt, 0);
    check("rst_olast", o_last, 0);
    check("rst_busy", busy, 0);
    check("rst_iack", i_ack, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // 1: full word, back-to-back
    o_ack = 1'b1;
    push(32'h44332211, 2'd3, 1'b0);
    send(8'h11, 0, w); check("s1_iack0", w, 0);
    send(8'h22, 0, w); check("s1_iack1", w, 0);
    send(8'h33, 0, w); check("s1_iack2", w, 0);
    send(8'h44, 0, w); check("s1_iack3", w, 0);
    check("s1_ordy", o_rdy, 1);
    idle(2);

    // 2: early close with i_last, next word restarts at slot 0
    push(32'h00CCBBAA, 2'd2, 1'b1);
    send(8'hAA, 0, w);
    send(8'hBB, 0, w);
    send(8'hCC, 1, w);
    check("s2_ordy", o_rdy, 1);
    send(8'h55, 0, w);
    idle(1);
    check("s2_busy", busy, 1);
    push(32'h00006655, 2'd1, 1'b1);
    send(8'h66, 1, w);
    idle(2);

    // 3: single-word packet
    push(32'h0000007E, 2'd0, 1'b1);
    send(8'h7E, 1, w);
    check("s3_busy", busy, 0);
    idle(2);

    // 4: backpressure holds output and input
    o_ack = 1'b0;
    push(32'hD4C3B2A1, 2'd3, 1'b0);
    send(8'hA1, 0, w);
    send(8'hB2, 0, w);
    send(8'hC3, 0, w);
    send(8'hD4, 0, w);
    i_rdy = 1'b1; i_data = 8'hE5; i_last = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("s4_iack_low", i_ack, 0);
      check("s4_odata_hold", o_data, 32'hD4C3B2A1);
      @(posedge clk); #1;
    end
    o_ack = 1'b1;
    @(negedge clk);
    check("s4_iack_high", i_ack, 1);
    @(posedge clk); #1;
    o_ack = 1'b0; i_rdy = 1'b0;
    check("s4_busy", busy, 1);
    check("s4_ordy", o_rdy, 0);
    o_ack = 1'b1;
    push(32'h0000F6E5, 2'd1, 1'b1);
    send(8'hF6, 1, w);
    idle(2);

    // 5: reset mid-packet discards the partial word
    send(8'h10, 0, w);
    send(8'h20, 0, w);
    idle(1);
    check("s5_busy_pre", busy, 1);
    rst_n = 1'b0;
    #2;
    check("s5_ordy", o_rdy, 0);
    check("s5_busy", busy, 0);
    check("s5_odata", o_data, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    push(32'h04030201, 2'd3, 1'b0);
    send(8'h01, 0, w);
    send(8'h02, 0, w);
    send(8'h03, 0, w);
    send(8'h04, 0, w);
    idle(2);

    // 6: drain and completion on the same edge
    push(32'h00000001, 2'd0, 1'b1);
    push(32'h00000002, 2'd0, 1'b1);
    send(8'h01, 1, w);
    send(8'h02, 1, w);
    check("s6_ordy_kept", o_rdy, 1);
    check("s6_iack_nostall", w, 0);
    idle(2);

    // 6b: random traffic against a reference model
    verbose = 1'b0;
    m_idx = 0;
    for (int k = 0; k < 4; k++) m_acc[k] = '0;
    fork
      begin
        for (int n = 0; n < 2000; n++) begin
          logic [7:0] d;
          logic l;
          if ($urandom_range(0, 3) == 0) idle(1);
          d = 8'($urandom);
          l = (n == 1999) || ($urandom_range(0, 6) == 0);
          send(d, l, w);
          m_acc[m_idx] = d;
          if (m_idx == 3 || l) begin
            push({m_acc[3], m_acc[2], m_acc[1], m_acc[0]}, 2'(m_idx), l);
            for (int k = 0; k < 4; k++) m_acc[k] = '0;
            m_idx = 0;
          end else begin
            m_idx++;
          end
        end
        i_rdy = 1'b0;
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk); #1;
          o_ack = ($urandom_range(0, 3) != 0);
        end
      end
    join
    o_ack = 1'b1;
    for (int c = 0; c < 20 && sb_q.size() != 0; c++) begin
      @(posedge clk); #1;
    end
    check("drain_empty", sb_q.size(), 0);
    check("final_busy", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
